axi_lite_mem_rd_bridge: RTL and testbench
=========================================

// Module: axi_lite_mem_rd_bridge
// PURPOSE
//  AXI4-Lite read-only slave that lets an external host read the data memory over its I/O read port.
//  Accepts AR requests and drives the memory's AXI word address. Captures the 1-cycle-latency
//  synchronous read data and returns it on the R channel. Sits directly in front of data_mem's axi_A/axi_RD pins.
// PARAMETERS
//  DATA_WIDTH       32      R-channel / memory data width
//  ADDR_WIDTH       32      AXI and memory address width
//  ADDR_REAL_WIDTH  15      memory word-index width (size = 4<<ADDR_REAL_WIDTH bytes)
//  BASE_ADDR        32'h0   AXI byte address mapped to memory byte 0
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           async active-low reset
//  s_axi_araddr   in   ADDR_WIDTH  read byte address
//  s_axi_arvalid  in   1           AR valid
//  s_axi_arready  out  1           AR ready
//  s_axi_rdata    out  DATA_WIDTH  read data
//  s_axi_rresp    out  2           2'b00 OKAY, 2'b10 SLVERR
//  s_axi_rvalid   out  1           R valid
//  s_axi_rready   in   1           R ready
//  mem_A          out  ADDR_WIDTH  byte offset to memory axi_A (araddr - BASE_ADDR)
//  mem_RD         in   DATA_WIDTH  memory axi_RD; valid the cycle after mem_A is sampled
// BEHAVIOUR
//  - One clock: clk. Reset: rst_n is asynchronous and active-low.
//  - All outputs are registered.
//  - Reset values: arready=0, rvalid=0, rdata=0, rresp=0, mem_A=0, state=IDLE.
//  - FSM states: IDLE, RD0, RD1, RESP. One transaction outstanding at a time.
//  - IDLE (arready=1): on arvalid&&arready, latch mem_A<=araddr-BASE_ADDR and clear arready.
//    - If the request is good: IDLE->RD0.
//    - If the request has an error (see CONFIGURATION): IDLE->RESP with rdata=0, rresp=2'b10.
//  - RD0: the memory samples mem_A at the end of this cycle. ->RD1.
//  - RD1: at the end of the cycle rdata<=mem_RD, rresp<=2'b00, rvalid<=1. ->RESP.
//  - RESP: rvalid, rdata and rresp are held stable until rready.
//    - On rvalid&&rready: rvalid<=0, arready<=1, ->IDLE.
//  - Latency: AR handshake in cycle N; rvalid high from cycle N+3 (N+1 for an error response).
//  - Throughput: the next AR handshake is possible at the earliest one cycle after the R handshake.
//  - mem_A is held constant from the AR handshake until the next AR handshake.
//  - araddr is only sampled on the handshake; changes while arready=0 are ignored.
//  - Subtraction is modulo 2^ADDR_WIDTH. Memory uses bits [ADDR_REAL_WIDTH+1:2] only.
//  - A concurrent CPU write to the same word during RD0 returns the OLD word (memory is read-first).
//  - Reset mid-transaction:
//    - all outputs are forced to reset values immediately; state returns to IDLE.
//    - no pending response is replayed.
//    - arready rises on the first clk edge after rst_n deasserts.
// CONFIGURATION
//  AXI_RD_ERR_CHECK_EN defined:
//    - a request is an error if araddr[1:0]!=0, or araddr<BASE_ADDR,
//      or araddr>=BASE_ADDR+(4<<ADDR_REAL_WIDTH).
//    - error requests never change mem_A usage semantics: no memory read occurs;
//      response is SLVERR, rdata=0.
//  AXI_RD_ERR_CHECK_EN undefined:
//    - no error detection; rresp is always 2'b00.
//    - out-of-range addresses wrap modulo memory size; low 2 bits are ignored.
// TESTING
//  1. Preload word 5=32'hDEADBEEF; AR araddr=0x14, rready=1
//     -> rvalid at handshake+3, rdata=DEADBEEF, rresp=00.
//  2. Same read with rready=0 for 5 cycles
//     -> rvalid/rdata/rresp stable throughout, arready=0; completes when rready=1.
//  3. arvalid held with araddr 0x0 then 0x4 back-to-back (words 0x11,0x22)
//     -> R responses 0x11 then 0x22 in order; second AR handshake one cycle after first R handshake.
//  4. With macro, araddr=0x0002_0000 and araddr=0x6
//     -> each returns rresp=10, rdata=0, rvalid at handshake+1.
//     Without macro, 0x0002_0000 -> word 0 data, OKAY.
//  5. rst_n low during RD1
//     -> rvalid=0, arready=0 immediately; after release arready=1 at next edge, no stray rvalid.
//  6. CPU writes 0xCAFE to word 3 in the same cycle as RD0 of AR 0xC (old 0x1234)
//     -> rdata=0x1234; a subsequent read returns 0xCAFE.

Source files
------------

// File: rtl/axi_lite_mem_rd_bridge.sv
// ----------------------------------------------------------------------------
// axi_lite_mem_rd_bridge
//
// Read-only AXI4-Lite slave that gives an external host access to the data
// memory through the memory's I/O read port (axi_A / axi_RD). Only one read is
// outstanding at a time. The memory has a 1-cycle synchronous read, so every
// read takes two internal cycles (RD0: address sampled, RD1: data captured)
// before the response appears on R.
//
// Optional feature (compile-time macro): AXI_RD_ERR_CHECK_EN
//   defined   : misaligned or out-of-window addresses get an immediate SLVERR
//               with rdata = 0 and no memory read.
//   undefined : no checking; rresp is always OKAY. Out-of-window addresses
//               wrap modulo the memory size and the low two bits are ignored.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   s_axi_araddr   AR byte address (sampled only on the AR handshake)
//   s_axi_arvalid  AR valid
//   s_axi_arready  AR ready (registered)
//   s_axi_rdata    R data (registered, stable until accepted)
//   s_axi_rresp    R response: 2'b00 OKAY, 2'b10 SLVERR
//   s_axi_rvalid   R valid (registered)
//   s_axi_rready   R ready
//   mem_A          byte offset into memory (araddr - BASE_ADDR), held between
//                  AR handshakes
//   mem_RD         memory read data, valid the cycle after mem_A is sampled
// ----------------------------------------------------------------------------
module axi_lite_mem_rd_bridge #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    ADDR_REAL_WIDTH = 15,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ADDR_WIDTH-1:0] mem_A,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // log2 of the memory size in bytes
    localparam int         SIZE_SH     = ADDR_REAL_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

    state_t                state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;

    // Next mem_A value; subtraction wraps modulo 2^ADDR_WIDTH.
    logic [ADDR_WIDTH-1:0] mem_a_d;
    assign mem_a_d = s_axi_araddr - BASE_ADDR;

    // Offset beyond the memory window. Checked on the offset rather than on
    // BASE_ADDR + size so the comparison itself cannot overflow.
    logic oor;
    generate
        if (SIZE_SH >= ADDR_WIDTH) begin : g_oor_none
            assign oor = 1'b0;
        end else begin : g_oor_chk
            assign oor = (mem_a_d >> SIZE_SH) != '0;
        end
    endgenerate

    logic req_err;
`ifdef AXI_RD_ERR_CHECK_EN
    assign req_err = (s_axi_araddr[1:0] != 2'b00) ||
                     (s_axi_araddr < BASE_ADDR)   ||
                     oor;
`else
    logic unused_oor;
    assign unused_oor = oor;
    assign req_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            mem_a_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // arready is low only on the first cycle out of reset.
                    if (!arready_q) begin
                        arready_q <= 1'b1;
                    end else if (s_axi_arvalid) begin
                        arready_q <= 1'b0;
                        mem_a_q   <= mem_a_d;
                        if (req_err) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= '0;
                            rresp_q  <= RESP_SLVERR;
                            state_q  <= RESP;
                        end else begin
                            state_q  <= RD0;
                        end
                    end
                end
                // Memory samples mem_A at the end of this cycle.
                RD0: state_q <= RD1;
                RD1: begin
                    rdata_q  <= mem_RD;
                    rresp_q  <= RESP_OKAY;
                    rvalid_q <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign mem_A         = mem_a_q;

endmodule

// File: tb/tb_axi_lite_mem_rd_bridge.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_mem_rd_bridge
//
// Directed bench for axi_lite_mem_rd_bridge with a behavioural read-first,
// 1-cycle-latency data memory that also has a CPU write port. Expected R
// beats are queued when an AR request is driven and popped when the R
// handshake happens.
// ----------------------------------------------------------------------------
module tb_axi_lite_mem_rd_bridge;

    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          ARW  = 15;
    localparam logic [31:0] BASE = 32'h0;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_RD;

    axi_lite_mem_rd_bridge #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .ADDR_REAL_WIDTH (ARW),
        .BASE_ADDR       (BASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .mem_A         (mem_A),
        .mem_RD        (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first memory: the read sees the value before a same-edge write.
    logic [DW-1:0]  mem [0:(1<<ARW)-1];
    logic           cpu_we;
    logic [ARW-1:0] cpu_widx;
    logic [DW-1:0]  cpu_wd;

    always @(posedge clk) begin
        mem_RD <= mem[mem_A[ARW+1:2]];
        if (cpu_we) mem[cpu_widx] <= cpu_wd;
    end

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [ARW-1:0] idx, input logic [31:0] d);
        cpu_we   = 1'b1;
        cpu_widx = idx;
        cpu_wd   = d;
        @(posedge clk); #1;
        cpu_we   = 1'b0;
    endtask

    // One full read. Entered and left at posedge+1.
    //   exp_lat : extra edges from the AR handshake edge until rvalid is seen
    //   hold    : cycles rready stays low once rvalid is up
    //   keep    : leave arvalid high and move araddr to next_addr after the
    //             handshake (the change must be ignored by this transaction)
    //   wr_en   : CPU write to (widx, wdat) during the RD0 cycle
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input int exp_lat, input int hold,
                           input bit keep, input logic [31:0] next_addr,
                           input bit wr_en, input logic [ARW-1:0] widx,
                           input logic [31:0] wdat);
        int   k;
        exp_t e;
        exp_q.push_back('{data: exp_data, resp: exp_resp});
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        k = 0;
        while (!s_axi_arready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "/arready_wait"}, 64'(s_axi_arready), 64'(1'b1));
        @(posedge clk); #1;  // AR handshake edge
        if (keep) s_axi_araddr = next_addr;
        else      s_axi_arvalid = 1'b0;
        chk({tag, "/mem_A"}, 64'(mem_A), 64'(addr - BASE));
        chk({tag, "/arready_low"}, 64'(s_axi_arready), 64'(1'b0));
        if (wr_en) begin
            cpu_we   = 1'b1;
            cpu_widx = widx;
            cpu_wd   = wdat;
        end
        s_axi_rready = (hold == 0);
        k = 0;
        while (!s_axi_rvalid && k < 20) begin
            @(posedge clk); #1;
            cpu_we = 1'b0;
            k++;
        end
        cpu_we = 1'b0;
        chk({tag, "/latency"}, 64'(k), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold"}, {28'd0, s_axi_rvalid, s_axi_arready, s_axi_rresp, s_axi_rdata},
                {28'd0, 1'b1, 1'b0, exp_resp, exp_data});
        end
        s_axi_rready = 1'b1;
        e = exp_q.pop_front();
        chk({tag, "/rbeat"}, {29'd0, s_axi_rvalid, s_axi_rresp, s_axi_rdata},
            {29'd0, 1'b1, e.resp, e.data});
        chk({tag, "/mem_A_held"}, 64'(mem_A), 64'(addr - BASE));
        @(posedge clk); #1;  // R handshake edge
        chk({tag, "/after_r"}, {62'd0, s_axi_rvalid, s_axi_arready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        cpu_we        = 1'b0;
        cpu_widx      = '0;
        cpu_wd        = '0;
        #12;
        chk("reset/outs", {28'd0, s_axi_arready, s_axi_rvalid, s_axi_rresp, s_axi_rdata},
            64'd0);
        chk("reset/mem_A", 64'(mem_A), 64'd0);

        // Preload while still in reset.
        @(posedge clk); #1;
        cpu_wr(15'd5, 32'hDEADBEEF);
        cpu_wr(15'd0, 32'h11);
        cpu_wr(15'd1, 32'h22);
        cpu_wr(15'd3, 32'h1234);
        chk("reset/arready_held", 64'(s_axi_arready), 64'd0);

        rst_n = 1'b1;
        #1;
        chk("release/arready_before_edge", 64'(s_axi_arready), 64'd0);
        @(posedge clk); #1;
        chk("release/arready_first_edge", 64'(s_axi_arready), 64'd1);

        // 1: basic read
        do_read("t1", 32'h14, 32'hDEADBEEF, 2'b00, 2, 0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        // 2: back-pressure on R
        do_read("t2", 32'h14, 32'hDEADBEEF, 2'b00, 2, 5, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        // 3: arvalid held, address changes while arready low
        do_read("t3a", 32'h0, 32'h11, 2'b00, 2, 0, 1'b1, 32'h4, 1'b0, '0, 32'h0);
        do_read("t3b", 32'h4, 32'h22, 2'b00, 2, 0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        // 4: out-of-window and misaligned
`ifdef AXI_RD_ERR_CHECK_EN
        do_read("t4a", 32'h0002_0000, 32'h0, 2'b10, 0, 0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        do_read("t4b", 32'h6, 32'h0, 2'b10, 0, 0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
`else
        do_read("t4a", 32'h0002_0000, 32'h11, 2'b00, 2, 0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        do_read("t4b", 32'h6, 32'h22, 2'b00, 2, 0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
`endif

        // 5: reset asserted during RD1
        s_axi_rready  = 1'b1;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 32'h14;
        chk("t5/arready", 64'(s_axi_arready), 64'd1);
        @(posedge clk); #1;  // handshake -> RD0
        s_axi_arvalid = 1'b0;
        @(posedge clk); #1;  // RD1
        rst_n = 1'b0;
        #1;
        chk("t5/async_outs", {28'd0, s_axi_arready, s_axi_rvalid, s_axi_rresp, s_axi_rdata},
            64'd0);
        chk("t5/async_mem_A", 64'(mem_A), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("t5/arready_before_edge", 64'(s_axi_arready), 64'd0);
        @(posedge clk); #1;
        chk("t5/arready_first_edge", {62'd0, s_axi_arready, s_axi_rvalid}, {62'd0, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t5/no_stray_rvalid", 64'(s_axi_rvalid), 64'd0);
        end

        // 6: CPU write collides with RD0 -> old word, then new word
        do_read("t6a", 32'hC, 32'h1234, 2'b00, 2, 0, 1'b0, 32'h0, 1'b1, 15'd3, 32'hCAFE);
        do_read("t6b", 32'hC, 32'hCAFE, 2'b00, 2, 0, 1'b0, 32'h0, 1'b0, '0, 32'h0);

        chk("scoreboard/empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
